// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, frame size and the baud divider helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_FRAME_BITS = 10;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through dout; count is registered.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only slots behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/arduino_uart_tx.sv
// UART 8N1 transmitter to the Arduino: start bit 1 cycle after a push into an idle block,
// frames are 10*CLKS_PER_BIT cycles and back-to-back; tx_ready drops when the FIFO is full.
module arduino_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        arduino_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("arduino_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("arduino_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t          state_q, state_d;
    logic [BCW-1:0]     cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         sh_q, sh_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               fifo_pop;
    logic [7:0]         fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               baud_end;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready   = !fifo_full;
    assign arduino_tx = tx_q;
    assign busy       = busy_q;
    assign baud_end   = (cnt_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = baud_end ? '0 : cnt_q + BCW'(1);
        idx_d    = idx_q;
        sh_d     = sh_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // A queued byte starts its start bit right after this stop bit.
                if (baud_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line and busy are registered from the next state so they align with it.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_arduino_uart_tx.sv
// Randomized scoreboard bench for arduino_uart_tx with a frame-level reference model.
module tb_arduino_uart_tx;

    localparam int C     = 16;
    localparam int D     = 4;
    localparam int FRAME = 10 * C;
    localparam int CW    = $clog2(D) + 1;

    logic          clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_ready;
    logic          arduino_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    arduino_uart_tx #(
        .CLK_FREQ     (50_000_000),
        .BAUD         (9600),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .arduino_tx (arduino_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Default-parameter instance, used only for the bit-width measurement.
    logic          rst2 = 1'b1;
    logic          v2 = 1'b0;
    logic [7:0]    d2 = 8'h00;
    logic          rdy2;
    logic          tx2;
    logic          busy2;
    logic [CW-1:0] cnt2;

    arduino_uart_tx dut_def (
        .clk        (clk),
        .rst        (rst2),
        .tx_data    (d2),
        .tx_valid   (v2),
        .tx_ready   (rdy2),
        .arduino_tx (tx2),
        .busy       (busy2),
        .fifo_count (cnt2)
    );

    int         total = 0;
    int         bad = 0;

    // Reference model: a byte queue plus the remaining length of the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         frame_left = 0;
    logic [7:0] cur = 8'h00;
    int         rst_epoch = 0;
    bit         init_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_line();
        int p;
        int b;
        if (frame_left == 0) return 1'b1;
        p = FRAME - frame_left;
        b = p / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    initial begin
        int  pre;
        bit  acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                sb.delete();
                frame_left = 0;
                rst_epoch++;
                init_done = 1;
            end else begin
                pre = mq.size();
                acc = tx_valid && (pre < D);
                if ((frame_left <= 1) && (pre > 0)) begin
                    cur = mq.pop_front();
                    sb.push_back(cur);
                    frame_left = FRAME;
                end else if (frame_left > 0) begin
                    frame_left--;
                end
                if (acc) mq.push_back(tx_data);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (init_done) begin
                check("line", {31'd0, arduino_tx}, {31'd0, exp_line()});
                check("busy", {31'd0, busy}, {31'd0, frame_left > 0});
                check("fifo_count", 32'(fifo_count), 32'(mq.size()));
                check("tx_ready", {31'd0, tx_ready}, {31'd0, mq.size() < D});
            end
        end
    end

    // Monitor: decodes the serial line at bit midpoints and pops the scoreboard.
    initial begin
        int         cnt;
        int         k;
        int         ep;
        bit         act;
        logic [7:0] by;
        cnt = 0;
        ep  = 0;
        act = 0;
        by  = 8'h00;
        forever begin
            @(negedge clk);
            if (init_done) begin
                if (rst_epoch != ep) begin
                    ep  = rst_epoch;
                    act = 0;
                end
                if (!act) begin
                    if (arduino_tx === 1'b0) begin
                        act = 1;
                        cnt = 0;
                    end
                end else begin
                    cnt++;
                end
                if (act && (cnt % C == C / 2)) begin
                    k = cnt / C;
                    if (k == 0) begin
                        check("start_bit", {31'd0, arduino_tx}, 32'd0);
                    end else if (k <= 8) begin
                        by[k-1] = arduino_tx;
                    end else begin
                        check("stop_bit", {31'd0, arduino_tx}, 32'd1);
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL frame at %0t: unexpected byte %02h on line", $time, by);
                        end else begin
                            check("frame_byte", {24'd0, by}, {24'd0, sb.pop_front()});
                        end
                    end
                end
                if (act && (cnt == FRAME - 1)) act = 0;
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] d);
        @(negedge clk);
        tx_valid = v;
        tx_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom));
    endtask

    initial begin
        time t0;
        time t1;
        bit  found;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(100);

        drive(1'b1, 8'h34);
        idle(200);

        drive(1'b1, 8'h30);
        drive(1'b1, 8'h31);
        drive(1'b1, 8'h36);
        idle(520);

        for (int i = 0; i < 6; i++) drive(1'b1, 8'hA0 + 8'(i));
        idle(6 * FRAME + 50);

        // Push lands on the edge that ends the first frame's stop bit.
        drive(1'b1, 8'h41);
        drive(1'b1, 8'h42);
        drive(1'b1, 8'h43);
        idle(158);
        drive(1'b1, 8'h44);
        drive(1'b0, 8'h00);
        check("simul_count", 32'(fifo_count), 32'd2);
        idle(3 * FRAME + 60);

        // Reset lands in data bit 3 of 0x55 with two bytes queued.
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        idle(70);
        @(negedge clk);
        tx_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        check("rst_line", {31'd0, arduino_tx}, 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        idle(400);

        for (int i = 0; i < 400; i++) drive($urandom_range(0, 99) < 20, 8'($urandom));
        idle(8 * FRAME);
        check("drain", 32'(sb.size() + mq.size()), 32'd0);

        // Default CLKS_PER_BIT: time from start-bit fall to bit0 rise for byte 0x01.
        @(negedge clk);
        rst2 = 1'b0;
        v2   = 1'b1;
        d2   = 8'h01;
        @(negedge clk);
        v2   = 1'b0;
        d2   = 8'hFF;
        found = 0;
        t0 = 0;
        t1 = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx2 === 1'b0) begin
                found = 1;
                t0 = $time;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL default_start: start bit not seen within 20 cycles");
        end else begin
            found = 0;
            for (int i = 0; i < 6000 && !found; i++) begin
                @(negedge clk);
                if (tx2 === 1'b1) begin
                    found = 1;
                    t1 = $time;
                end
            end
            if (!found) begin
                total++;
                bad++;
                $display("FAIL default_bit: bit0 not seen within 6000 cycles");
            end else begin
                check("default_bit_ns", 32'(t1 - t0), 32'd104160);
            end
        end
        rst2 = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
